pipeline_stall_ctrl: RTL and testbench

Pipeline freeze/bubble controller for the five-stage processor. It consumes the HDU `Stall` request, the EX-stage branch flush request and the MEM-stage multi-cycle memory request. It turns them into per-stage write enables, flushes and bubbles, and guarantees exactly one bubble per load-use hazard. It also keeps a saturating count of frozen cycles for debug.

---
 rtl/pipeline_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline freeze/bubble controller with saturating frozen-cycle counter
module pipeline_stall_ctrl #(
    parameter int unsigned MEM_EXTRA_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        En,
    input  logic        Stall,
    input  logic        Flush_Req,
    input  logic        Mem_Multi,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Write,
    output logic        IDEX_Bubble,
    output logic        EXMEM_Write,
    output logic        MEMWB_Bubble,
    output logic [1:0]  Ctrl_State,
    output logic [15:0] Stall_Count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_HOLD   = 2'd2
    } state_t;

    // Frozen cycles still owed after the cycle that accepts a Mem_Multi request.
    localparam logic [2:0] HOLD_LOAD = 3'(MEM_EXTRA_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  hold_cnt_q, hold_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    // Next-state, hold counter and Mealy stage controls from registered state and live requests.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Write  = 1'b1;
        MEMWB_Bubble = 1'b0;

        case (state_q)
            ST_RUN, ST_LOAD_STALL: begin
                if (Mem_Multi) begin
                    PC_Write     = 1'b0;
                    IFID_Write   = 1'b0;
                    IDEX_Write   = 1'b0;
                    EXMEM_Write  = 1'b0;
                    MEMWB_Bubble = 1'b1;
                    if (MEM_EXTRA_CYCLES == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_cnt_d = HOLD_LOAD;
                        state_d    = ST_MEM_HOLD;
                    end
                end else if (Flush_Req) begin
                    // Branch wins over a same-cycle load-use stall; the stalled op is squashed anyway.
                    IFID_Flush  = 1'b1;
                    IDEX_Bubble = 1'b1;
                    state_d     = ST_RUN;
                end else if (Stall && En && (state_q == ST_RUN)) begin
                    // Only RUN may bubble, so a level Stall yields exactly one bubble per hazard.
                    PC_Write    = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    state_d     = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_HOLD: begin
                // EX is frozen, so a pending flush simply waits until RUN.
                PC_Write     = 1'b0;
                IFID_Write   = 1'b0;
                IDEX_Write   = 1'b0;
                EXMEM_Write  = 1'b0;
                MEMWB_Bubble = 1'b1;
                if (hold_cnt_q <= 3'd1) begin
                    hold_cnt_d = 3'd0;
                    state_d    = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                hold_cnt_d = 3'd0;
            end
        endcase

        // Reset freezes every stage and loads NOPs everywhere.
        if (rst) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IFID_Flush   = 1'b1;
            IDEX_Write   = 1'b0;
            IDEX_Bubble  = 1'b1;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
        end

        stall_count_d = stall_count_q;
        if (!PC_Write && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // State, hold counter and debug counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            hold_cnt_q    <= 3'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign Ctrl_State  = state_q;
    assign Stall_Count = stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    localparam int M = 3;

    // Output vector order: PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble
    localparam logic [6:0] O_NORMAL = 7'b1101010;
    localparam logic [6:0] O_HOLD   = 7'b0000001;
    localparam logic [6:0] O_FLUSH  = 7'b1111110;
    localparam logic [6:0] O_BUBBLE = 7'b0001110;
    localparam logic [6:0] O_RESET  = 7'b0010101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, stall = 1'b0, flush = 1'b0, mem = 1'b0;
    logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count;

    typedef struct {
        logic [6:0]  outs;
        logic [1:0]  st;
        logic [15:0] cnt;
        bit          chk_regs;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: frozen cycles still owed, whether the last cycle was a load bubble, frozen count.
    int owed = 0;
    bit last_bubble = 0;
    int frozen = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_EXTRA_CYCLES(M)) dut (
        .clk(clk), .rst(rst), .En(en), .Stall(stall), .Flush_Req(flush), .Mem_Multi(mem),
        .PC_Write(pc_w), .IFID_Write(ifid_w), .IFID_Flush(ifid_f), .IDEX_Write(idex_w),
        .IDEX_Bubble(idex_b), .EXMEM_Write(exmem_w), .MEMWB_Bubble(memwb_b),
        .Ctrl_State(ctrl_state), .Stall_Count(stall_count)
    );

    task automatic step(input logic r, input logic e, input logic s, input logic f, input logic m);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; en = e; stall = s; flush = f; mem = m;
        x.cyc = cyc;
        cyc++;
        x.chk_regs = !r;
        x.cnt = 16'(frozen);
        if (owed > 0) x.st = 2'd2;
        else if (last_bubble) x.st = 2'd1;
        else x.st = 2'd0;
        if (r) begin
            x.outs = O_RESET;
            owed = 0; last_bubble = 0; frozen = 0;
        end else begin
            if (owed > 0) begin
                x.outs = O_HOLD; owed--;
            end else if (m) begin
                x.outs = O_HOLD; owed = M - 1; last_bubble = 0;
            end else if (f) begin
                x.outs = O_FLUSH; last_bubble = 0;
            end else if (s && e && !last_bubble) begin
                x.outs = O_BUBBLE; last_bubble = 1;
            end else begin
                x.outs = O_NORMAL; last_bubble = 0;
            end
            if (!x.outs[6] && frozen < 65535) frozen++;
        end
        sb.push_back(x);
    endtask

    task automatic check(input string name, input int c, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle and match against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check("stage_ctrl", x.cyc, {9'd0, pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b},
                  {9'd0, x.outs});
            if (x.chk_regs) begin
                check("ctrl_state", x.cyc, {14'd0, ctrl_state}, {14'd0, x.st});
                check("stall_count", x.cyc, stall_count, x.cnt);
            end
        end
    end

    initial begin
        // Reset, then idle RUN
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        // Level Stall held 3 cycles: bubble, normal, bubble
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        // Stall masked by En=0
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        // Stall with Flush: flush wins
        step(0, 1, 1, 1, 0);
        step(0, 1, 0, 0, 0);
        // Mem pulse with Flush held: 3 frozen cycles then flush in RUN
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Back-to-back branch
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        // Reset on 2nd MEM_HOLD cycle aborts the hold
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Mem_Multi held: new request starts in first RUN after each hold
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 99) < 2), logic'($urandom_range(0, 99) < 80),
                 logic'($urandom_range(0, 99) < 45), logic'($urandom_range(0, 99) < 20),
                 logic'($urandom_range(0, 99) < 10));
        end
        // Saturation: continuous freeze well past 65535 cycles
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
